// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between a load/store unit and data_memory_ctrl.
// The master drives requests and the slave returns a single-cycle response pulse.
interface data_memory_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// Single-port data memory with byte lanes, wait states, range checking and a post-reset clear sweep.
// Storage is split into one 8-bit lane instance per byte so that byte enables map onto lane write enables.
module data_memory_lane #(
   parameter int DEPTH = 4096,
   parameter int IDX_W = 12
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [7:0]       wdata,
   output logic [7:0]       rdata
);
   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[idx] <= wdata;

   assign rdata = mem[idx];
endmodule

module data_memory_ctrl #(
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 12,
   parameter int DEPTH          = 4096,
   parameter int WAIT_STATES    = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   data_memory_ctrl_if.slave  bus,
   output logic               busy
);
   localparam int NUM_LANES = DATA_W / 8;
   localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   logic [1:0]                      state;
   logic [IDX_W-1:0]                ptr;
   logic [3:0]                      cnt;
   logic [DATA_W-1:0]               pend_rdata;
   logic                            pend_err;

   logic                            accept;
   logic                            in_range;
   logic                            clr_we;
   logic [IDX_W-1:0]                idx;
   logic [NUM_LANES-1:0]            lane_we;
   logic [NUM_LANES-1:0][7:0]       lane_wd;
   logic [NUM_LANES-1:0][7:0]       lane_rd;
   logic [NUM_LANES-1:0][7:0]       merged;
   logic [DATA_W-1:0]               rsp_word;

   assign bus.req_ready = (state == ST_IDLE);
   assign busy          = (state == ST_CLEAR);
   assign accept        = bus.req_valid && bus.req_ready;
   assign in_range      = {1'b0, bus.req_addr} < DEPTH_L;
   // Gate with rst_n so nothing is written while reset is still held.
   assign clr_we        = busy && (CLEAR_ON_RESET != 0) && rst_n;
   assign idx           = busy ? ptr : bus.req_addr[IDX_W-1:0];
   assign rsp_word      = in_range ? DATA_W'(merged) : '0;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lane_we[i] = clr_we || (accept && in_range && bus.req_we && bus.req_be[i]);
      assign lane_wd[i] = clr_we ? 8'h00 : bus.req_wdata[8*i +: 8];
      // Write-first: the response carries the post-write word.
      assign merged[i]  = (bus.req_we && bus.req_be[i]) ? bus.req_wdata[8*i +: 8] : lane_rd[i];

      data_memory_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
         .clk   (clk),
         .we    (lane_we[i]),
         .idx   (idx),
         .wdata (lane_wd[i]),
         .rdata (lane_rd[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_CLEAR;
         ptr           <= '0;
         cnt           <= '0;
         pend_rdata    <= '0;
         pend_err      <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            ST_CLEAR: begin
               if (CLEAR_ON_RESET == 0 || ptr == LAST) begin
                  state <= ST_IDLE;
                  ptr   <= '0;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  if (WAIT_STATES == 0) begin
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_rdata <= rsp_word;
                     bus.rsp_err   <= !in_range;
                  end else begin
                     state      <= ST_WAIT;
                     cnt        <= 4'(WAIT_STATES - 1);
                     pend_rdata <= rsp_word;
                     pend_err   <= !in_range;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd0) begin
                  state         <= ST_IDLE;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= pend_rdata;
                  bus.rsp_err   <= pend_err;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: four controller configurations share one request driver, selected by sel.
// Table vectors cover single transactions; hand sequences cover throughput, wait states and reset.
module tb_data_memory_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        valid, we;
   logic [11:0] addr;
   logic [15:0] wdata;
   logic [1:0]  be;
   int          sel;

   int checks   = 0;
   int failures = 0;

   data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(12)) if0 ();
   data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(12)) if1 ();
   data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(12)) if2 ();
   data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(12)) if3 ();

   logic        busy_a   [4];
   logic        ready_a  [4];
   logic        rvalid_a [4];
   logic [15:0] rdata_a  [4];
   logic        err_a    [4];

   assign if0.req_valid = valid && (sel == 0);
   assign if1.req_valid = valid && (sel == 1);
   assign if2.req_valid = valid && (sel == 2);
   assign if3.req_valid = valid && (sel == 3);
   assign if0.req_we = we;       assign if1.req_we = we;       assign if2.req_we = we;       assign if3.req_we = we;
   assign if0.req_addr = addr;   assign if1.req_addr = addr;   assign if2.req_addr = addr;   assign if3.req_addr = addr;
   assign if0.req_wdata = wdata; assign if1.req_wdata = wdata; assign if2.req_wdata = wdata; assign if3.req_wdata = wdata;
   assign if0.req_be = be;       assign if1.req_be = be;       assign if2.req_be = be;       assign if3.req_be = be;

   assign ready_a[0] = if0.req_ready; assign rvalid_a[0] = if0.rsp_valid; assign rdata_a[0] = if0.rsp_rdata; assign err_a[0] = if0.rsp_err;
   assign ready_a[1] = if1.req_ready; assign rvalid_a[1] = if1.rsp_valid; assign rdata_a[1] = if1.rsp_rdata; assign err_a[1] = if1.rsp_err;
   assign ready_a[2] = if2.req_ready; assign rvalid_a[2] = if2.rsp_valid; assign rdata_a[2] = if2.rsp_rdata; assign err_a[2] = if2.rsp_err;
   assign ready_a[3] = if3.req_ready; assign rvalid_a[3] = if3.rsp_valid; assign rdata_a[3] = if3.rsp_rdata; assign err_a[3] = if3.rsp_err;

   // 0: defaults; 1: 3 wait states, 64 words; 2: 2048 words; 3: 5 wait states, 32 words
   data_memory_ctrl #(.DATA_W(16), .ADDR_W(12), .DEPTH(4096), .WAIT_STATES(0), .CLEAR_ON_RESET(1))
      u0 (.clk(clk), .rst_n(rst_n), .bus(if0), .busy(busy_a[0]));
   data_memory_ctrl #(.DATA_W(16), .ADDR_W(12), .DEPTH(64), .WAIT_STATES(3), .CLEAR_ON_RESET(1))
      u1 (.clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy_a[1]));
   data_memory_ctrl #(.DATA_W(16), .ADDR_W(12), .DEPTH(2048), .WAIT_STATES(0), .CLEAR_ON_RESET(1))
      u2 (.clk(clk), .rst_n(rst_n), .bus(if2), .busy(busy_a[2]));
   data_memory_ctrl #(.DATA_W(16), .ADDR_W(12), .DEPTH(32), .WAIT_STATES(5), .CLEAR_ON_RESET(1))
      u3 (.clk(clk), .rst_n(rst_n), .bus(if3), .busy(busy_a[3]));

   logic        o_ready, o_rvalid, o_err;
   logic [15:0] o_rdata;
   assign o_ready  = ready_a[sel];
   assign o_rvalid = rvalid_a[sel];
   assign o_rdata  = rdata_a[sel];
   assign o_err    = err_a[sel];

   typedef struct {
      int          sel;
      logic        we;
      logic [11:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      logic [15:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;
   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic do_req(input logic w, input logic [11:0] a, input logic [15:0] d, input logic [1:0] b,
                         output logic [15:0] rd, output logic er, output int lat);
      int n;
      @(negedge clk);
      valid = 1'b1; we = w; addr = a; wdata = d; be = b;
      n = 0;
      while (!o_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("accept_timeout", 32'd0, 32'd1);
      @(negedge clk);
      valid = 1'b0;
      lat = 1;
      while (!o_rvalid && lat < 50) begin @(negedge clk); lat++; end
      rd = o_rdata;
      er = o_err;
   endtask

   // Waits for every sweep to finish and checks each lasted its DEPTH cycles.
   task automatic sweep_check(input string tag);
      int n;
      int nb[4];
      logic ready_while_busy;
      int depth_a[4];
      depth_a = '{4096, 64, 2048, 32};
      nb = '{0, 0, 0, 0};
      ready_while_busy = 1'b0;
      n = 0;
      while ((busy_a[0] || busy_a[1] || busy_a[2] || busy_a[3]) && n < 5000) begin
         for (int k = 0; k < 4; k++) if (busy_a[k] && ready_a[k]) ready_while_busy = 1'b1;
         @(negedge clk);
         n++;
         for (int k = 0; k < 4; k++) if (!busy_a[k] && nb[k] == 0) nb[k] = n;
      end
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_sweep_len%0d", tag, k), 32'(nb[k]), 32'(depth_a[k]));
         chk($sformatf("%s_ready_after%0d", tag, k), {31'd0, ready_a[k]}, 32'd1);
      end
      chk({tag, "_ready_while_busy"}, {31'd0, ready_while_busy}, 32'd0);
   endtask

   initial begin
      logic [15:0] rd;
      logic        er;
      int          lat;
      logic        saw;

      valid = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; sel = 0;
      rst_n = 1'b0;

      vt.push_back('{0, 1'b0, 12'h7F1, 16'h0000, 2'b11, 16'h0000, 1'b0, 1});
      vt.push_back('{0, 1'b1, 12'h301, 16'h1234, 2'b11, 16'h1234, 1'b0, 1});
      vt.push_back('{0, 1'b1, 12'h301, 16'hAB00, 2'b10, 16'hAB34, 1'b0, 1});
      vt.push_back('{0, 1'b0, 12'h301, 16'h0000, 2'b00, 16'hAB34, 1'b0, 1});
      vt.push_back('{0, 1'b1, 12'h301, 16'h00CD, 2'b01, 16'hABCD, 1'b0, 1});
      vt.push_back('{0, 1'b1, 12'h301, 16'hFFFF, 2'b00, 16'hABCD, 1'b0, 1});
      vt.push_back('{0, 1'b0, 12'h301, 16'h0000, 2'b11, 16'hABCD, 1'b0, 1});
      vt.push_back('{0, 1'b1, 12'hFFF, 16'h5A5A, 2'b11, 16'h5A5A, 1'b0, 1});
      vt.push_back('{0, 1'b0, 12'hFFF, 16'h0000, 2'b11, 16'h5A5A, 1'b0, 1});
      vt.push_back('{0, 1'b0, 12'h000, 16'h0000, 2'b11, 16'h0000, 1'b0, 1});
      vt.push_back('{0, 1'b1, 12'h100, 16'h0000, 2'b11, 16'h0000, 1'b0, 1});
      vt.push_back('{0, 1'b1, 12'h101, 16'h0001, 2'b11, 16'h0001, 1'b0, 1});
      vt.push_back('{0, 1'b1, 12'h102, 16'h0002, 2'b11, 16'h0002, 1'b0, 1});
      vt.push_back('{0, 1'b1, 12'h103, 16'h0003, 2'b11, 16'h0003, 1'b0, 1});
      vt.push_back('{1, 1'b1, 12'h03F, 16'hBEEF, 2'b11, 16'hBEEF, 1'b0, 4});
      vt.push_back('{1, 1'b0, 12'h03F, 16'h0000, 2'b11, 16'hBEEF, 1'b0, 4});
      vt.push_back('{1, 1'b0, 12'h040, 16'h0000, 2'b11, 16'h0000, 1'b1, 4});
      vt.push_back('{1, 1'b1, 12'h040, 16'h1111, 2'b11, 16'h0000, 1'b1, 4});
      vt.push_back('{2, 1'b1, 12'h800, 16'hFFFF, 2'b11, 16'h0000, 1'b1, 1});
      vt.push_back('{2, 1'b0, 12'h000, 16'h0000, 2'b11, 16'h0000, 1'b0, 1});
      vt.push_back('{2, 1'b1, 12'h7FF, 16'h00C3, 2'b01, 16'h00C3, 1'b0, 1});
      vt.push_back('{2, 1'b0, 12'hFFF, 16'h0000, 2'b11, 16'h0000, 1'b1, 1});
      vt.push_back('{2, 1'b0, 12'h7FF, 16'h0000, 2'b11, 16'h00C3, 1'b0, 1});
      vt.push_back('{3, 1'b1, 12'h003, 16'h0077, 2'b11, 16'h0077, 1'b0, 6});

      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_busy%0d", k),   {31'd0, busy_a[k]},   32'd1);
         chk($sformatf("rst_ready%0d", k),  {31'd0, ready_a[k]},  32'd0);
         chk($sformatf("rst_rvalid%0d", k), {31'd0, rvalid_a[k]}, 32'd0);
         chk($sformatf("rst_rdata%0d", k),  {16'd0, rdata_a[k]},  32'd0);
         chk($sformatf("rst_err%0d", k),    {31'd0, err_a[k]},    32'd0);
      end
      rst_n = 1'b1;
      sweep_check("init");

      foreach (vt[i]) begin
         sel = vt[i].sel;
         do_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, er, lat);
         chk($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vt[i].exp_rdata});
         chk($sformatf("vec%0d_err", i),   {31'd0, er}, {31'd0, vt[i].exp_err});
         chk($sformatf("vec%0d_lat", i),   32'(lat),    32'(vt[i].exp_lat));
      end

      // Back-to-back reads of 0x100..0x103: one response per cycle.
      sel = 0;
      @(negedge clk);
      valid = 1'b1; we = 1'b0; be = 2'b11; addr = 12'h100;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk($sformatf("tput%0d_rvalid", j), {31'd0, o_rvalid}, 32'd1);
         chk($sformatf("tput%0d_rdata", j),  {16'd0, o_rdata},  32'(j));
         if (j < 3) addr = 12'(12'h101 + j);
         else valid = 1'b0;
      end
      @(negedge clk);
      chk("tput_idle_rvalid", {31'd0, o_rvalid}, 32'd0);
      chk("tput_hold_rdata",  {16'd0, o_rdata},  32'd3);

      // Three wait states with a second request held through the wait.
      sel = 1;
      @(negedge clk);
      valid = 1'b1; we = 1'b1; addr = 12'h005; wdata = 16'h0042; be = 2'b11;
      lat = 0;
      while (!o_ready && lat < 200) begin @(negedge clk); lat++; end
      @(negedge clk);
      we = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         chk($sformatf("ws_ready_low%0d", j),  {31'd0, o_ready},  32'd0);
         chk($sformatf("ws_rvalid_low%0d", j), {31'd0, o_rvalid}, 32'd0);
         @(negedge clk);
      end
      chk("ws_rvalid_at4", {31'd0, o_rvalid}, 32'd1);
      chk("ws_ready_at4",  {31'd0, o_ready},  32'd1);
      chk("ws_rdata_at4",  {16'd0, o_rdata},  32'h42);
      @(negedge clk);
      chk("ws_second_accepted", {31'd0, o_ready}, 32'd0);
      valid = 1'b0;
      lat = 1;
      while (!o_rvalid && lat < 50) begin @(negedge clk); lat++; end
      chk("ws_second_lat",   32'(lat),          32'd4);
      chk("ws_second_rdata", {16'd0, o_rdata},  32'h42);

      // Reset while a 5-wait-state read is in flight.
      sel = 3;
      @(negedge clk);
      valid = 1'b1; we = 1'b0; addr = 12'h003; be = 2'b11;
      lat = 0;
      while (!o_ready && lat < 200) begin @(negedge clk); lat++; end
      @(negedge clk);
      valid = 1'b0;
      saw = o_rvalid;
      @(negedge clk);
      saw = saw | o_rvalid;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_rst_rvalid", {31'd0, o_rvalid}, 32'd0);
      chk("mid_rst_rdata",  {16'd0, o_rdata},  32'd0);
      chk("mid_rst_err",    {31'd0, o_err},    32'd0);
      chk("mid_rst_busy",   {31'd0, busy_a[3]}, 32'd1);
      rst_n = 1'b1;
      fork
         sweep_check("rerun");
         for (int j = 0; j < 4200; j++) begin
            @(negedge clk);
            saw = saw | o_rvalid;
         end
      join
      chk("mid_rst_no_rsp", {31'd0, saw}, 32'd0);

      do_req(1'b0, 12'h003, 16'h0000, 2'b11, rd, er, lat);
      chk("post_rst_rdata3", {16'd0, rd}, 32'd0);
      chk("post_rst_lat3",   32'(lat),    32'd6);
      sel = 0;
      do_req(1'b0, 12'h301, 16'h0000, 2'b11, rd, er, lat);
      chk("post_rst_rdata0", {16'd0, rd}, 32'd0);
      chk("post_rst_err0",   {31'd0, er}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised single-port data memory with a valid/ready request port and a one-cycle response pulse.
- Adds configurable wait states, byte-lane write enables, out-of-range detection and a hardware clear sweep after reset.
- Sits between the core's load/store unit and data storage, and replaces the fixed 16x4096 data memory.
- All logic is on the rising edge of clk.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8
ADDR_W, 12, request address width
DEPTH, 4096, number of words implemented; must satisfy DEPTH <= 2**ADDR_W
WAIT_STATES, 0, extra cycles between accept and response; legal range 0..15
CLEAR_ON_RESET, 1, 1 = sweep all DEPTH words to 0 after reset release

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  DATA_W/8  byte-lane enables; bit i covers bits [8i+7:8i]
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  response data
rsp_err  out  1  address out of range; qualified by rsp_valid
busy  out  1  clear sweep in progress

Behaviour:
- States: CLEAR, IDLE, WAIT.
- Reset state is CLEAR. Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, clear pointer=0, wait counter=0.
- req_ready = (state==IDLE); busy = (state==CLEAR). Both are decoded from state, so during reset req_ready=0 and busy=1.
- CLEAR with CLEAR_ON_RESET=1:
  - writes 0 to address ptr each cycle, ptr increments;
  - after writing DEPTH-1, moves to IDLE;
  - the sweep takes exactly DEPTH cycles after rst_n rises.
- CLEAR with CLEAR_ON_RESET=0: performs no writes and moves to IDLE after 1 cycle. Memory contents are then undefined.
- Accept: a request is accepted at a rising edge where req_valid && req_ready. Requests are ignored in CLEAR and WAIT; the requester must hold req_valid.
- In range (req_addr < DEPTH):
  - on the accept edge, if req_we, write lanes where req_be[i]=1 and keep the other lanes;
  - the response data is the word after any write (write-first); a write is acknowledged with the merged word.
  - req_we=1 with req_be=0 changes nothing but still responds.
- Out of range (req_addr >= DEPTH): no write is performed, rsp_rdata=0, rsp_err=1.
- WAIT_STATES=0:
  - state stays IDLE;
  - rsp_valid pulses in the cycle after the accept edge;
  - back-to-back accepts give one response per cycle.
- WAIT_STATES=N>0:
  - the accept edge moves the state to WAIT and loads the counter with N-1;
  - WAIT decrements the counter;
  - on the edge where the counter is 0, the state returns to IDLE and rsp_valid pulses.
  - Latency is N+1 cycles from accept to rsp_valid.
  - req_ready rises in the same cycle rsp_valid pulses.
- rsp_valid is high for exactly one cycle; there is no response back-pressure.
- rsp_rdata and rsp_err hold their last value when rsp_valid=0.
- A read in the cycle after a write to the same address returns the new data.
- Reset mid-operation:
  - an in-flight request is dropped with no response;
  - any write already committed on its accept edge persists unless the sweep clears it;
  - the sweep restarts from address 0.
- Address wrap: none. Addresses at or above DEPTH are errors and never alias.

Test Plan:
1. Defaults. Release reset -> busy=1 and req_ready=0 for 4096 cycles, then req_ready=1. Read addr 0x7F1 -> rsp_rdata=0x0000, rsp_err=0, rsp_valid 1 cycle after accept.
2. Byte enables. Write 0x1234 be=2'b11 to 0x301. Then write 0xAB00 be=2'b10 to 0x301 -> response 0xAB34. Read 0x301 -> 0xAB34.
3. Throughput. WAIT_STATES=0, back-to-back reads of 0x100..0x103 preloaded with 0..3 -> four consecutive rsp_valid cycles carrying 0,1,2,3.
4. Wait states. WAIT_STATES=3, read -> rsp_valid exactly 4 cycles after accept. req_ready=0 for 3 cycles, and a second held request is accepted on the rsp_valid cycle.
5. Out of range. DEPTH=2048, ADDR_W=12, write 0xFFFF to 0x800 -> rsp_err=1, rsp_rdata=0. Read 0x000 -> 0 (no alias write).
6. Reset mid-operation. WAIT_STATES=5, accept a read, assert rst_n low 2 cycles later -> no rsp_valid, outputs 0. After release the sweep repeats (busy=1 for DEPTH cycles).
